// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared constants and fetch-state type for the MIPS fetch stage
package mips_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] WORD_BYTES       = 32'd4;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/if_stage_if.sv
// rtl/if_stage_if.sv - instruction memory read bus between fetch stage and memory
interface if_stage_if;

    logic [31:0] imem_addr;
    logic        imem_rd;
    logic [31:0] imem_data;

    modport master (output imem_addr, output imem_rd, input imem_data);
    modport slave  (input imem_addr, input imem_rd, output imem_data);

endinterface

// File: rtl/if_stage_ifid_reg.sv
// rtl/if_stage_ifid_reg.sv - IF/ID pipeline register with hold and squash controls
module ifid_reg
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic        squash_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc4_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc4_o,
    output logic        valid_o
);

    logic [31:0] instr_q;
    logic [31:0] pc4_q;
    logic        valid_q;

    // Squash beats load; neither asserted means hold.
    always_ff @(posedge clk) begin
        if (rst || squash_i) begin
            instr_q <= NOP_INSTR;
            pc4_q   <= 32'h0;
            valid_q <= 1'b0;
        end else if (load_i) begin
            instr_q <= instr_i;
            pc4_q   <= pc4_i;
            valid_q <= 1'b1;
        end
    end

    assign instr_o = instr_q;
    assign pc4_o   = pc4_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - MIPS instruction fetch stage: PC, fetch FSM, IF/ID register
// Optional build macro: IF_STAGE_PERF_EN adds fetched/bubble counters.
module if_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int          IMEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        flush_i,
    if_stage_if.master  imem,
    output logic [31:0] ifid_instr_o,
    output logic [31:0] ifid_pc4_o,
    output logic        ifid_valid_o,
`ifdef IF_STAGE_PERF_EN
    output logic [31:0] perf_fetched_o,
    output logic [31:0] perf_bubbles_o,
`endif
    output logic        fetch_err_o
);

    localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_BYTES);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         fetch_err_q, fetch_err_d;
    logic         ifid_load, ifid_squash;
    logic [31:0]  pc_plus4, redir_pc;
    logic         redir_misaligned, redir_in_range, out_of_range;

    assign pc_plus4         = pc_q + WORD_BYTES;
    assign redir_pc         = {redirect_pc_i[31:2], 2'b00};
    assign redir_misaligned = |redirect_pc_i[1:0];
    assign redir_in_range   = redir_pc < IMEM_LIMIT;
    assign out_of_range     = pc_q >= IMEM_LIMIT;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= BOOT;
            pc_q        <= RESET_PC;
            fetch_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            fetch_err_q <= fetch_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        fetch_err_d  = fetch_err_q;
        ifid_load    = 1'b0;
        ifid_squash  = 1'b0;
        imem.imem_rd = 1'b0;
        case (state_q)
            BOOT: begin
                ifid_squash = 1'b1;
                state_d     = RUN;
            end
            RUN: begin
                imem.imem_rd = 1'b1;
                // Redirect outranks both the out-of-range halt and a data stall.
                if (redirect_valid_i) begin
                    pc_d        = redir_pc;
                    ifid_squash = 1'b1;
                    if (redir_misaligned) fetch_err_d = 1'b1;
                end else if (out_of_range) begin
                    ifid_squash = 1'b1;
                    fetch_err_d = 1'b1;
                    state_d     = HALT;
                end else begin
                    if (!stall_i) pc_d = pc_plus4;
                    if (flush_i)       ifid_squash = 1'b1;
                    else if (!stall_i) ifid_load   = 1'b1;
                end
            end
            HALT: begin
                ifid_squash = 1'b1;
                if (redirect_valid_i && redir_in_range) begin
                    pc_d    = redir_pc;
                    state_d = RUN;
                    if (redir_misaligned) fetch_err_d = 1'b1;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    assign imem.imem_addr = pc_q;
    assign fetch_err_o    = fetch_err_q;

    ifid_reg u_ifid_reg (
        .clk      (clk),
        .rst      (rst),
        .load_i   (ifid_load),
        .squash_i (ifid_squash),
        .instr_i  (imem.imem_data),
        .pc4_i    (pc_plus4),
        .instr_o  (ifid_instr_o),
        .pc4_o    (ifid_pc4_o),
        .valid_o  (ifid_valid_o)
    );

`ifdef IF_STAGE_PERF_EN
    logic [31:0] perf_fetched_q, perf_bubbles_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched_q <= 32'h0;
            perf_bubbles_q <= 32'h0;
        end else begin
            if (ifid_load && (perf_fetched_q != 32'hFFFF_FFFF))
                perf_fetched_q <= perf_fetched_q + 32'd1;
            if ((state_q == RUN) && !ifid_load && (perf_bubbles_q != 32'hFFFF_FFFF))
                perf_bubbles_q <= perf_bubbles_q + 32'd1;
        end
    end

    assign perf_fetched_o = perf_fetched_q;
    assign perf_bubbles_o = perf_bubbles_q;
`endif

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage pipelined MIPS core.
- Owns the PC register and drives the address and read-enable of the instruction memory read block.
- Captures the returned instruction word into the IF/ID pipeline register.
- Handles hazard stalls, branch/jump redirects, flushes and out-of-range fetch halting.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_BYTES, 1024, instruction memory size in bytes (256 words); fetch at PC >= IMEM_BYTES is out of range.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- stall  input  1  hazard-unit stall; hold PC and IF/ID.
- redirect_valid  input  1  branch/jump taken, resolved downstream.
- redirect_pc  input  32  branch/jump target byte address.
- flush  input  1  squash IF/ID contents without changing the PC.
- imem_addr  output  32  byte address to instruction memory (= pc).
- imem_rd  output  1  instruction memory read enable.
- imem_data  input  32  instruction word; combinational, valid the same cycle as imem_addr.
- ifid_instr  output  32  registered instruction to decode.
- ifid_pc4  output  32  registered PC+4 of that instruction.
- ifid_valid  output  1  IF/ID holds a real instruction.
- fetch_err  output  1  sticky; set on out-of-range fetch or misaligned redirect.

Behaviour:
- Reset, sampled on clk while rst=1:
  - pc=RESET_PC; state=BOOT.
  - ifid_instr=32'h0 (NOP); ifid_pc4=0; ifid_valid=0; fetch_err=0.
  - rst overrides all other inputs.
  - Reset asserted mid-operation discards any in-flight instruction.
- Memory interface:
  - imem_addr=pc, combinational.
  - imem_rd=1 in RUN, else 0.
  - Instruction latency: word at pc appears on ifid_instr one cycle after pc is presented.
- States:
  - BOOT: exactly one cycle after reset release. imem_rd=0, ifid_valid=0, pc unchanged. Goes to RUN.
  - RUN: normal fetch.
  - HALT: out-of-range fetch detected. imem_rd=0; IF/ID loaded with NOP, valid=0; pc held. Exits to RUN only on redirect_valid with an in-range target.
- Next-PC priority in RUN (highest first):
  - redirect_valid: pc = {redirect_pc[31:2], 2'b00}. If redirect_pc[1:0] != 0, set fetch_err.
  - stall: pc held.
  - otherwise: pc = pc+4, modulo 2^32 (0xFFFF_FFFC wraps to 0).
- IF/ID update in RUN (highest first):
  - redirect_valid or flush: load NOP, valid=0, pc4=0.
  - stall: hold all IF/ID fields.
  - otherwise: instr=imem_data, pc4=pc+4, valid=1.
- Simultaneous events:
  - redirect + stall: redirect wins; the control hazard overrides the data stall.
  - flush + stall: IF/ID is squashed and pc is held.
- Out-of-range:
  - In RUN with pc >= IMEM_BYTES: do not capture imem_data; load NOP, valid=0; set fetch_err; enter HALT next cycle.
  - A redirect in the same cycle takes priority and keeps the stage in RUN.
- fetch_err clears only on rst.

Optional Feature:
- Macro: IF_STAGE_PERF_EN.
- When defined, adds two 32-bit output counters, perf_fetched and perf_bubbles:
  - perf_fetched increments each cycle IF/ID loads a valid instruction.
  - perf_bubbles increments each cycle in RUN that IF/ID does not load a valid instruction (stall, flush, redirect or out-of-range).
  - Both reset to 0 and saturate at 32'hFFFF_FFFF.
- When undefined, the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package mips_pkg holds:
  - NOP_INSTR=32'h0.
  - RESET_PC default.
  - WORD_BYTES=4.
  - fetch-state enum {BOOT, RUN, HALT}.
- One natural sub-module: ifid_reg, the IF/ID pipeline register with hold/squash controls. PC and FSM logic stay in if_stage.

Test Plan:
- Reset release, memory words 0..3 preloaded, no stalls:
  - cycle 1 BOOT with ifid_valid=0.
  - then ifid_instr = words 0,1,2,3 on consecutive cycles.
  - ifid_pc4 = 4,8,12,16.
- Stall held 3 cycles while pc=8: pc stays 8 and IF/ID holds word 1 / pc4=8; after release the stream resumes with word 2.
- redirect_valid with redirect_pc=0x40, asserted together with stall:
  - next cycle ifid_valid=0 and pc=0x40.
  - following cycle ifid_pc4=0x44.
- redirect_pc=0x42: pc=0x40, fetch_err=1, and fetch continues.
- pc reaches 0x400 with IMEM_BYTES=1024:
  - ifid_valid=0, fetch_err=1, state HALT, imem_rd=0.
  - redirect to 0x0 resumes fetch of word 0.
- rst asserted mid-stream with ifid_valid=1: next cycle pc=RESET_PC, ifid_instr=0, ifid_valid=0, fetch_err=0.
